execute_mdu_stage: RTL and testbench

- Parametrised successor to the RV32I execute stage: holds the D->E pipeline register, runs the single-cycle ALU, and adds an iterative multiply/divide unit (RV M-extension ops).
- Sits between decode and memory stages using the valid/allow_in handshake.
- Stalls decode via e_allow_in while a multi-cycle op is in flight.
- Supports a flush input and holds its state under back-pressure (registers are never zeroed while stalled).

---
 rtl/execute_mdu_stage_if.sv | 42 ++++
 rtl/execute_mdu_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_execute_mdu_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/execute_mdu_stage_if.sv
// ---------------------------------------------------------------------------
// execute_mdu_stage_if
// Bundles the decode->execute->memory handshake and data buses of the
// execute stage into one interface.
//   master : upstream/downstream environment (decode + memory side)
//   slave  : the execute stage itself
// Signals:
//   d_to_e_valid, D_pc, D_op, D_src1, D_src2, D_rd : incoming instruction
//   m_allow_in, flush                               : downstream/redirect control
//   e_allow_in, e_to_m_valid                        : execute handshake outputs
//   e_valid, E_pc, E_rd, e_valE, e_busy             : execute stage state/result
// ---------------------------------------------------------------------------
interface execute_mdu_stage_if #(
   parameter int XLEN = 32,
   parameter int OPW  = 5
);
   logic            d_to_e_valid;
   logic            e_allow_in;
   logic            m_allow_in;
   logic            e_to_m_valid;
   logic            flush;
   logic [XLEN-1:0] D_pc;
   logic [OPW-1:0]  D_op;
   logic [XLEN-1:0] D_src1;
   logic [XLEN-1:0] D_src2;
   logic [4:0]      D_rd;
   logic            e_valid;
   logic [XLEN-1:0] E_pc;
   logic [4:0]      E_rd;
   logic [XLEN-1:0] e_valE;
   logic            e_busy;

   modport master (
      output d_to_e_valid, m_allow_in, flush, D_pc, D_op, D_src1, D_src2, D_rd,
      input  e_allow_in, e_to_m_valid, e_valid, E_pc, E_rd, e_valE, e_busy
   );

   modport slave (
      input  d_to_e_valid, m_allow_in, flush, D_pc, D_op, D_src1, D_src2, D_rd,
      output e_allow_in, e_to_m_valid, e_valid, E_pc, E_rd, e_valE, e_busy
   );
endinterface

// File: rtl/execute_mdu_stage.sv
// ---------------------------------------------------------------------------
// execute_mdu_stage
// RV32I-style execute stage with the D->E pipeline register, a single-cycle
// ALU and an iterative multiply/divide unit (one bit per cycle).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : execute_mdu_stage_if.slave (handshake, operands, results)
// Optional build macro MDU_SINGLE_CYCLE_MUL_EN: when defined, MUL/MULH/
// MULHSU/MULHU use a combinational multiplier and finish in one cycle;
// the FSM then serves divides only.
// ---------------------------------------------------------------------------
module execute_mdu_stage #(
   parameter int XLEN = 32,
   parameter int OPW  = 5,
   parameter int CNTW = 6
) (
   input logic                clk,
   input logic                rst,
   execute_mdu_stage_if.slave bus
);
   localparam int SHW = $clog2(XLEN);
   localparam logic [OPW-1:0] OP_ADD = OPW'(0),  OP_SUB = OPW'(1),  OP_SLL = OPW'(2);
   localparam logic [OPW-1:0] OP_SLT = OPW'(3),  OP_SLTU = OPW'(4), OP_XOR = OPW'(5);
   localparam logic [OPW-1:0] OP_SRL = OPW'(6),  OP_SRA = OPW'(7),  OP_OR = OPW'(8);
   localparam logic [OPW-1:0] OP_AND = OPW'(9),  OP_MUL = OPW'(10), OP_MULH = OPW'(11);
   localparam logic [OPW-1:0] OP_MULHSU = OPW'(12), OP_MULHU = OPW'(13), OP_DIV = OPW'(14);
   localparam logic [OPW-1:0] OP_DIVU = OPW'(15), OP_REM = OPW'(16), OP_REMU = OPW'(17);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNTW-1:0] LAST = CNTW'(XLEN-1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t state, state_nx;
   logic e_valid_r;
   logic [XLEN-1:0] pc_r, src1_r, src2_r;
   logic [4:0] rd_r;
   logic [OPW-1:0] op_r;
   logic [CNTW-1:0] cnt, cnt_nx;
   logic [XLEN-1:0] hi, hi_nx, lo, lo_nx, opnd, opnd_nx, res, res_nx;
   logic neg_a, neg_a_nx, neg_b, neg_b_nx;
   logic is_div, mdu_iter, sgn1, sgn2, neg1, neg2, ready_go, allow_in;
   logic [XLEN-1:0] abs1, abs2, alu_res, step_hi, step_lo, quo_fix, rem_fix, fin_res;
   logic [XLEN:0] mul_sum, div_rs, div_diff;
   logic div_ge;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [SHW-1:0] shamt;

   // Operation classification and operand sign handling. neg_a ends up as the
   // sign of the product/quotient, neg_b as the sign of the remainder.
   assign is_div = (op_r >= OP_DIV) && (op_r <= OP_REMU);
`ifdef MDU_SINGLE_CYCLE_MUL_EN
   assign mdu_iter = is_div;
`else
   assign mdu_iter = is_div || ((op_r >= OP_MUL) && (op_r <= OP_MULHU));
`endif
   assign sgn1  = (op_r == OP_MUL) || (op_r == OP_MULH) || (op_r == OP_MULHSU) ||
                  (op_r == OP_DIV) || (op_r == OP_REM);
   assign sgn2  = (op_r == OP_MUL) || (op_r == OP_MULH) ||
                  (op_r == OP_DIV) || (op_r == OP_REM);
   assign neg1  = sgn1 && src1_r[XLEN-1];
   assign neg2  = sgn2 && src2_r[XLEN-1];
   assign abs1  = neg1 ? -src1_r : src1_r;
   assign abs2  = neg2 ? -src2_r : src2_r;
   assign shamt = src2_r[SHW-1:0];

   // Handshake: MDU ops hold the stage until the FSM reaches DONE.
   assign ready_go         = !mdu_iter || (state == DONE);
   assign allow_in         = !e_valid_r || (ready_go && bus.m_allow_in);
   assign bus.e_allow_in   = allow_in;
   assign bus.e_to_m_valid = e_valid_r && ready_go;
   assign bus.e_valid      = e_valid_r;
   assign bus.E_pc         = pc_r;
   assign bus.E_rd         = rd_r;
   assign bus.e_busy       = (state == BUSY);
   assign bus.e_valE       = mdu_iter ? res : alu_res;

   // D->E pipeline register. Contents only change on an accepted load, so a
   // stalled instruction keeps its operands; flush just drops the valid bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         e_valid_r <= 1'b0;
         pc_r      <= '0;
         rd_r      <= '0;
         op_r      <= '0;
         src1_r    <= '0;
         src2_r    <= '0;
      end else begin
         if (bus.flush)
            e_valid_r <= 1'b0;
         else if (allow_in)
            e_valid_r <= bus.d_to_e_valid;
         if (allow_in && bus.d_to_e_valid) begin
            pc_r   <= bus.D_pc;
            rd_r   <= bus.D_rd;
            op_r   <= bus.D_op;
            src1_r <= bus.D_src1;
            src2_r <= bus.D_src2;
         end
      end
   end

`ifdef MDU_SINGLE_CYCLE_MUL_EN
   // Combinational multiplier: sign-extend to 2*XLEN so one unsigned multiply
   // covers every signedness combination modulo 2^(2*XLEN).
   logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
   assign fast_a    = {{XLEN{neg1}}, src1_r};
   assign fast_b    = {{XLEN{neg2}}, src2_r};
   assign fast_prod = fast_a * fast_b;
`endif

   // Single-cycle ALU (and the fast multiplier when that build is selected).
   always_comb begin
      alu_res = '0;
      case (op_r)
         OP_ADD:  alu_res = src1_r + src2_r;
         OP_SUB:  alu_res = src1_r - src2_r;
         OP_SLL:  alu_res = src1_r << shamt;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src1_r) < $signed(src2_r)};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src1_r < src2_r};
         OP_XOR:  alu_res = src1_r ^ src2_r;
         OP_SRL:  alu_res = src1_r >> shamt;
         OP_SRA:  alu_res = XLEN'($signed(src1_r) >>> shamt);
         OP_OR:   alu_res = src1_r | src2_r;
         OP_AND:  alu_res = src1_r & src2_r;
`ifdef MDU_SINGLE_CYCLE_MUL_EN
         OP_MUL:  alu_res = fast_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: alu_res = fast_prod[2*XLEN-1:XLEN];
`endif
         default: alu_res = '0;
      endcase
   end

   // One MDU iteration on magnitudes. Multiply: shift-add with {hi,lo} as the
   // product shifting right. Divide: restoring, remainder in hi, dividend
   // shifting out of lo while quotient bits shift in. fin_res is the
   // sign-corrected result as it will look after this iteration.
   always_comb begin
      mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      div_rs   = {hi, lo[XLEN-1]};
      div_ge   = (div_rs >= {1'b0, opnd});
      div_diff = div_rs - {1'b0, opnd};
      if (is_div) begin
         step_hi = div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0];
         step_lo = {lo[XLEN-2:0], div_ge};
      end else begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], lo[XLEN-1:1]};
      end
      prod     = {step_hi, step_lo};
      prod_fix = neg_a ? -prod : prod;
      quo_fix  = neg_a ? -step_lo : step_lo;
      rem_fix  = neg_b ? -step_hi : step_hi;
      case (op_r)
         OP_MUL:                       fin_res = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fin_res = quo_fix;
         default:                      fin_res = rem_fix;
      endcase
   end

   // MDU FSM next-state and datapath updates. Divide-by-zero and signed
   // overflow are resolved straight from IDLE without iterating.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      hi_nx    = hi;
      lo_nx    = lo;
      opnd_nx  = opnd;
      neg_a_nx = neg_a;
      neg_b_nx = neg_b;
      res_nx   = res;
      if (bus.flush) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (e_valid_r && mdu_iter) begin
                  if (is_div && (src2_r == '0)) begin
                     res_nx   = ((op_r == OP_DIV) || (op_r == OP_DIVU)) ? '1 : src1_r;
                     state_nx = DONE;
                  end else if (is_div && sgn1 && (src1_r == MIN_NEG) && (src2_r == '1)) begin
                     res_nx   = (op_r == OP_DIV) ? src1_r : '0;
                     state_nx = DONE;
                  end else begin
                     hi_nx    = '0;
                     lo_nx    = abs1;
                     opnd_nx  = abs2;
                     neg_a_nx = neg1 ^ neg2;
                     neg_b_nx = neg1;
                     cnt_nx   = '0;
                     state_nx = BUSY;
                  end
               end
            end
            BUSY: begin
               hi_nx  = step_hi;
               lo_nx  = step_lo;
               cnt_nx = cnt + CNTW'(1);
               if (cnt == LAST) begin
                  res_nx   = fin_res;
                  state_nx = DONE;
               end
            end
            DONE: begin
               if (bus.m_allow_in)
                  state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // MDU state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         opnd  <= '0;
         neg_a <= 1'b0;
         neg_b <= 1'b0;
         res   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         hi    <= hi_nx;
         lo    <= lo_nx;
         opnd  <= opnd_nx;
         neg_a <= neg_a_nx;
         neg_b <= neg_b_nx;
         res   <= res_nx;
      end
   end
endmodule

// File: tb/tb_execute_mdu_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_mdu_stage
// Directed bench for execute_mdu_stage: ALU ops, iterative multiply/divide,
// divide special cases, back-pressure, back-to-back hand-off, flush and
// reset. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_execute_mdu_stage;
   localparam int XLEN = 32;
`ifdef MDU_SINGLE_CYCLE_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 34;
`endif
   localparam int DIV_LAT = 34;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int vectors = 0;
   int miscompares = 0;
   int cycles;

   execute_mdu_stage_if #(.XLEN(32), .OPW(5)) bus ();

   execute_mdu_stage #(.XLEN(32), .OPW(5), .CNTW(6)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction from decode.
   task automatic applyStimulus(input logic valid, input logic [4:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] pc, input logic [4:0] rd);
      bus.d_to_e_valid = valid;
      bus.D_op   = op;
      bus.D_src1 = a;
      bus.D_src2 = b;
      bus.D_pc   = pc;
      bus.D_rd   = rd;
   endtask

   // One comparison point.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Count cycles in E until the result is offered downstream (bounded).
   task automatic waitDone(output int n);
      n = 1;
      while (bus.e_to_m_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   // Single instruction through E with m_allow_in high; checks latency/value.
   task automatic runOp(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expVal, input int expLat);
      int n;
      applyStimulus(1'b1, op, a, b, 32'h200, 5'd7);
      tick();
      bus.d_to_e_valid = 1'b0;
      waitDone(n);
      checkOutput({tag, "_lat"}, n, expLat);
      checkOutput({tag, "_val"}, bus.e_valE, expVal);
      tick();
   endtask

   initial begin
      bus.m_allow_in = 1'b1;
      bus.flush = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0);

      // Reset state
      tick();
      tick();
      checkOutput("rst_valid", bus.e_valid, 1'b0);
      checkOutput("rst_tom", bus.e_to_m_valid, 1'b0);
      checkOutput("rst_busy", bus.e_busy, 1'b0);
      checkOutput("rst_valE", bus.e_valE, 32'h0);
      checkOutput("rst_allow", bus.e_allow_in, 1'b1);
      rst = 1'b1;

      // ADD completes in the same cycle it lands in E
      applyStimulus(1'b1, 5'd0, 32'd5, 32'hFFFF_FFFF, 32'h100, 5'd3);
      tick();
      bus.d_to_e_valid = 1'b0;
      checkOutput("add_tom", bus.e_to_m_valid, 1'b1);
      checkOutput("add_val", bus.e_valE, 32'd4);
      checkOutput("add_pc", bus.E_pc, 32'h100);
      checkOutput("add_rd", bus.E_rd, 5'd3);
      tick();
      checkOutput("add_gone", bus.e_valid, 1'b0);

      // Other ALU ops
      runOp("sub",  5'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1);
      runOp("sll",  5'd2, 32'd1, 32'd33, 32'd2, 1);
      runOp("slt",  5'd3, 32'hFFFF_FFFF, 32'd0, 32'd1, 1);
      runOp("sltu", 5'd4, 32'hFFFF_FFFF, 32'd0, 32'd0, 1);
      runOp("xor",  5'd5, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1);
      runOp("srl",  5'd6, 32'h8000_0000, 32'd4, 32'h0800_0000, 1);
      runOp("sra",  5'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
      runOp("or",   5'd8, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 1);
      runOp("and",  5'd9, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1);
      runOp("badop", 5'd20, 32'd1, 32'd2, 32'd0, 1);

      // Multiplies
      runOp("mul",    5'd10, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
      runOp("mulhu",  5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
      runOp("mulh",   5'd11, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, MUL_LAT);
      runOp("mulhsu", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);

      // DIVU under back-pressure, then REMU handed off back-to-back
      applyStimulus(1'b1, 5'd15, 32'd100, 32'd7, 32'h300, 5'd9);
      tick();
      bus.d_to_e_valid = 1'b0;
      bus.m_allow_in = 1'b0;
      waitDone(cycles);
      checkOutput("divu_lat", cycles, DIV_LAT);
      checkOutput("divu_val", bus.e_valE, 32'd14);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("bp_val", bus.e_valE, 32'd14);
         checkOutput("bp_allow", bus.e_allow_in, 1'b0);
      end
      applyStimulus(1'b1, 5'd17, 32'd100, 32'd7, 32'h304, 5'd10);
      bus.m_allow_in = 1'b1;
      #1;
      checkOutput("b2b_allow", bus.e_allow_in, 1'b1);
      tick();
      bus.d_to_e_valid = 1'b0;
      checkOutput("b2b_pc", bus.E_pc, 32'h304);
      waitDone(cycles);
      checkOutput("remu_lat", cycles, DIV_LAT);
      checkOutput("remu_val", bus.e_valE, 32'd2);
      tick();

      // Divide special cases and signed divides
      runOp("div_ovf",  5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
      runOp("rem_ovf",  5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2);
      runOp("divu_z",   5'd15, 32'd1234, 32'd0, 32'hFFFF_FFFF, 2);
      runOp("rem_z",    5'd16, 32'd9, 32'd0, 32'd9, 2);
      runOp("div_neg",  5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
      runOp("rem_neg",  5'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);

      // Flush on the 10th BUSY cycle, then an ADD
      applyStimulus(1'b1, 5'd14, 32'd1000, 32'd3, 32'h400, 5'd4);
      tick();
      bus.d_to_e_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      checkOutput("fl_busy_before", bus.e_busy, 1'b1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      checkOutput("fl_valid", bus.e_valid, 1'b0);
      checkOutput("fl_busy", bus.e_busy, 1'b0);
      checkOutput("fl_tom", bus.e_to_m_valid, 1'b0);
      runOp("add_after_fl", 5'd0, 32'd10, 32'd20, 32'd30, 1);

      // Reset in the middle of a divide
      applyStimulus(1'b1, 5'd15, 32'd100, 32'd7, 32'h500, 5'd5);
      tick();
      bus.d_to_e_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checkOutput("mr_busy_before", bus.e_busy, 1'b1);
      rst = 1'b0;
      tick();
      checkOutput("mr_valid", bus.e_valid, 1'b0);
      checkOutput("mr_busy", bus.e_busy, 1'b0);
      checkOutput("mr_tom", bus.e_to_m_valid, 1'b0);
      checkOutput("mr_valE", bus.e_valE, 32'h0);
      checkOutput("mr_pc", bus.E_pc, 32'h0);
      checkOutput("mr_rd", bus.E_rd, 5'd0);
      rst = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
